// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - address map, timer register offsets and CTRL bit positions
package mem_map_pkg;

    localparam logic [3:0] REG_RAM   = 4'h0;
    localparam logic [3:0] REG_LED   = 4'h1;
    localparam logic [3:0] REG_TIMER = 4'h2;
    localparam logic [3:0] REG_SW    = 4'h3;

    localparam logic [1:0] T_CTRL   = 2'd0;
    localparam logic [1:0] T_LOAD   = 2'd1;
    localparam logic [1:0] T_COUNT  = 2'd2;
    localparam logic [1:0] T_STATUS = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;

    function automatic logic [3:0] region_of(input logic [15:0] addr);
        return addr[15:12];
    endfunction

endpackage

// File: rtl/mem_timer.sv
// rtl/mem_timer.sv - prescaled interval timer with one-shot/auto-reload and sticky timeout
module mem_timer
    import mem_map_pkg::*;
#(
    parameter int PRESC = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr_en,
    input  logic [1:0]  i_offset,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_to
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);

    logic [PW-1:0] r_presc;
    logic          r_en;
    logic          r_auto;
    logic [15:0]   r_load;
    logic [15:0]   r_count;
    logic          r_to;

    logic w_ctrl_wr;
    logic w_load_wr;
    logic w_status_wr;
    logic w_tick;
    logic w_timeout;

    assign w_ctrl_wr   = i_wr_en && (i_offset == T_CTRL);
    assign w_load_wr   = i_wr_en && (i_offset == T_LOAD);
    assign w_status_wr = i_wr_en && (i_offset == T_STATUS);
    // A CTRL write restarts the prescaler and never ticks in its own cycle.
    assign w_tick      = r_en && (r_presc == PRESC_MAX) && !w_ctrl_wr;
    assign w_timeout   = w_tick && (r_count == 16'd0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc <= '0;
            r_en    <= 1'b0;
            r_auto  <= 1'b0;
            r_load  <= 16'd0;
            r_count <= 16'd0;
            r_to    <= 1'b0;
        end else begin
            if (w_ctrl_wr)
                r_presc <= '0;
            else if (r_en)
                r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + PW'(1);

            if (w_ctrl_wr) begin
                r_en   <= i_wdata[CTRL_EN];
                r_auto <= i_wdata[CTRL_AUTO];
            end else if (w_timeout && !r_auto) begin
                r_en <= 1'b0;
            end

            if (w_load_wr) begin
                r_load  <= i_wdata;
                r_count <= i_wdata;
            end else if (w_tick) begin
                if (r_count != 16'd0)
                    r_count <= r_count - 16'd1;
                else if (r_auto)
                    r_count <= r_load;
            end

            // Timeout set beats a same-cycle STATUS clear.
            if (w_timeout)
                r_to <= 1'b1;
            else if (w_status_wr)
                r_to <= 1'b0;
        end
    end

    always_comb begin
        o_rdata = 16'd0;
        case (i_offset)
            T_CTRL:   o_rdata = {14'd0, r_auto, r_en};
            T_LOAD:   o_rdata = r_load;
            T_COUNT:  o_rdata = r_count;
            T_STATUS: o_rdata = {15'd0, r_to};
            default:  o_rdata = 16'd0;
        endcase
    end

    assign o_to = r_to;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - processor-bus responder: RAM, LED register, timer and switch port
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int AW        = 8,
    parameter int PRESC     = 1,
    parameter     INIT_FILE = ""
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_dout,
    input  logic        i_w,
    output logic [15:0] o_din,
    input  logic [9:0]  i_sw,
    output logic [9:0]  o_ledr,
    output logic        o_timer_to
);

    logic [15:0] r_ram [0:(1<<AW)-1];
    logic [15:0] r_din;
    logic [9:0]  r_ledr;
    logic [9:0]  r_sw_meta;
    logic [9:0]  r_sw_sync;

    logic [3:0]    w_region;
    logic [AW-1:0] w_ram_idx;
    logic [15:0]   w_ram_q;
    logic [15:0]   w_timer_rdata;
    logic [15:0]   w_rdata;
    logic          w_ram_we;
    logic          w_timer_we;
    logic          w_unused_addr;

    assign w_region      = region_of(i_addr);
    assign w_ram_idx     = i_addr[AW-1:0];
    assign w_ram_q       = r_ram[w_ram_idx];
    assign w_ram_we      = i_w && !i_reset && (w_region == REG_RAM);
    assign w_timer_we    = i_w && (w_region == REG_TIMER);
    assign w_unused_addr = ^i_addr;

    always_ff @(posedge i_clock) begin
        if (w_ram_we)
            r_ram[w_ram_idx] <= i_dout;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ledr    <= 10'd0;
            r_sw_meta <= 10'd0;
            r_sw_sync <= 10'd0;
        end else begin
            r_sw_meta <= i_sw;
            r_sw_sync <= r_sw_meta;
            if (i_w && (w_region == REG_LED))
                r_ledr <= i_dout[9:0];
        end
    end

    mem_timer #(.PRESC(PRESC)) u_timer (
        .i_clk    (i_clock),
        .i_reset  (i_reset),
        .i_wr_en  (w_timer_we),
        .i_offset (i_addr[1:0]),
        .i_wdata  (i_dout),
        .o_rdata  (w_timer_rdata),
        .o_to     (o_timer_to)
    );

    always_comb begin
        w_rdata = 16'd0;
        case (w_region)
            REG_RAM:   w_rdata = w_ram_q;
            REG_LED:   w_rdata = {6'd0, r_ledr};
            REG_TIMER: w_rdata = w_timer_rdata;
            REG_SW:    w_rdata = {6'd0, r_sw_sync};
            default:   w_rdata = 16'd0;
        endcase
    end

    // Read-before-write falls out of sampling pre-edge state regardless of W.
    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_din <= 16'd0;
        else
            r_din <= w_rdata;
    end

    assign o_din  = r_din;
    assign o_ledr = r_ledr;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder against a behavioural model
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = 16'd0;
    logic [15:0] dout = 16'd0;
    logic        w = 1'b0;
    logic [15:0] din;
    logic [9:0]  sw = 10'd0;
    logic [9:0]  ledr;
    logic        timer_to;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] m_ram [256];
    bit          m_valid [256];
    logic [9:0]  m_led = 10'd0;
    logic [9:0]  m_meta = 10'd0;
    logic [9:0]  m_sync = 10'd0;
    logic        t_en = 1'b0, t_auto = 1'b0, t_to = 1'b0;
    logic [15:0] t_load = 16'd0, t_count = 16'd0;

    mem_responder #(.AW(8), .PRESC(1), .INIT_FILE("")) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_addr     (addr),
        .i_dout     (dout),
        .i_w        (w),
        .o_din      (din),
        .i_sw       (sw),
        .o_ledr     (ledr),
        .o_timer_to (timer_to)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [15:0] a);
        case (a[15:12])
            4'h0: return m_ram[a[7:0]];
            4'h1: return {6'd0, m_led};
            4'h2: case (a[1:0])
                      2'd0: return {14'd0, t_auto, t_en};
                      2'd1: return t_load;
                      2'd2: return t_count;
                      default: return {15'd0, t_to};
                  endcase
            4'h3: return {6'd0, m_sync};
            default: return 16'd0;
        endcase
    endfunction

    // One clock of the bus as seen by the processor, with PRESC=1 timer rules.
    task automatic m_update(input logic [15:0] a, input logic [15:0] d, input logic we);
        logic       twr, tick, timeout;
        logic [1:0] off;
        twr = we && (a[15:12] == 4'h2);
        off = a[1:0];
        tick = t_en && !(twr && off == 2'd0);
        timeout = tick && (t_count == 16'd0);
        if (we && a[15:12] == 4'h0) begin
            m_ram[a[7:0]] = d;
            m_valid[a[7:0]] = 1'b1;
        end
        if (we && a[15:12] == 4'h1) m_led = d[9:0];
        m_sync = m_meta;
        m_meta = sw;
        if (tick) begin
            if (t_count != 16'd0) t_count = t_count - 16'd1;
            else if (t_auto) t_count = t_load;
            else t_en = 1'b0;
        end
        if (twr && off == 2'd1) begin
            t_load = d;
            t_count = d;
        end
        if (twr && off == 2'd3 && !timeout) t_to = 1'b0;
        if (timeout) t_to = 1'b1;
        if (twr && off == 2'd0) begin
            t_en = d[0];
            t_auto = d[1];
        end
    endtask

    task automatic step(input logic [15:0] a, input logic [15:0] d, input logic we);
        logic [15:0] exp;
        bit          known;
        exp = m_read(a);
        known = !(a[15:12] == 4'h0 && !m_valid[a[7:0]]);
        m_update(a, d, we);
        addr = a; dout = d; w = we;
        @(posedge clk); #1;
        w = 1'b0;
        if (known) chk("din", din, exp);
        chk("ledr", {6'd0, ledr}, {6'd0, m_led});
        chk("timer_to", {15'd0, timer_to}, {15'd0, t_to});
    endtask

    task automatic do_reset(input logic [15:0] a, input logic [15:0] d, input logic we);
        rst = 1'b1; addr = a; dout = d; w = we;
        @(posedge clk); #1;
        rst = 1'b0; w = 1'b0;
        m_led = 10'd0; m_meta = 10'd0; m_sync = 10'd0;
        t_en = 1'b0; t_auto = 1'b0; t_to = 1'b0; t_load = 16'd0; t_count = 16'd0;
        chk("rst_din", din, 16'd0);
        chk("rst_ledr", {6'd0, ledr}, 16'd0);
        chk("rst_to", {15'd0, timer_to}, 16'd0);
    endtask

    initial begin
        int seq [6];
        logic [15:0] a, d;
        int r;
        seq = '{2, 1, 0, 2, 1, 0};

        do_reset(16'h0000, 16'h0000, 1'b0);
        do_reset(16'h0000, 16'h0000, 1'b0);

        // RAM write/read and aliasing
        step(16'h0005, 16'hBEEF, 1'b1);
        step(16'h0005, 16'h0000, 1'b0);
        chk("ram5", din, 16'hBEEF);
        step(16'h0105, 16'h0000, 1'b0);
        chk("ram5_alias", din, 16'hBEEF);

        // LED, switch synchronizer, unmapped region
        step(16'h1000, 16'h03A5, 1'b1);
        chk("ledr_3a5", {6'd0, ledr}, 16'h03A5);
        sw = 10'h155;
        step(16'h3000, 16'h0000, 1'b0);
        step(16'h3000, 16'h0000, 1'b0);
        chk("sw_2nd_edge_old", din, 16'h0000);
        step(16'h3000, 16'h0000, 1'b0);
        chk("sw_3rd_edge", din, 16'h0155);
        step(16'h7000, 16'hFFFF, 1'b1);
        chk("unmapped", din, 16'h0000);

        // One-shot timer
        step(16'h2001, 16'd3, 1'b1);
        step(16'h2000, 16'h0001, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(16'h2002, 16'h0000, 1'b0);
            chk("oneshot_count", din, 16'(3 - k));
        end
        chk("oneshot_to", {15'd0, timer_to}, 16'd1);
        step(16'h2000, 16'h0000, 1'b0);
        chk("oneshot_en_clear", din, 16'h0000);
        step(16'h2002, 16'h0000, 1'b0);
        chk("oneshot_count_hold", din, 16'h0000);
        step(16'h2003, 16'h0000, 1'b1);
        chk("status_clear", {15'd0, timer_to}, 16'd0);

        // Auto-reload timer
        step(16'h2001, 16'd2, 1'b1);
        step(16'h2000, 16'h0003, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step(16'h2002, 16'h0000, 1'b0);
            chk("auto_count", din, 16'(seq[k]));
            if (k == 2) chk("auto_first_to", {15'd0, timer_to}, 16'd1);
        end
        step(16'h2003, 16'h0000, 1'b1);
        chk("auto_status_clear", {15'd0, timer_to}, 16'd0);
        step(16'h2002, 16'h0000, 1'b0);
        step(16'h2003, 16'h0000, 1'b1);
        chk("status_vs_timeout", {15'd0, timer_to}, 16'd1);
        step(16'h2000, 16'h0000, 1'b1);

        // Read-before-write
        step(16'h0007, 16'h1111, 1'b1);
        step(16'h0007, 16'h2222, 1'b1);
        chk("rbw_old", din, 16'h1111);
        step(16'h0007, 16'h0000, 1'b0);
        chk("rbw_new", din, 16'h2222);

        // Reset mid-count together with an LED write
        step(16'h2001, 16'd5, 1'b1);
        step(16'h2000, 16'h0001, 1'b1);
        do_reset(16'h1000, 16'h03FF, 1'b1);
        step(16'h2002, 16'h0000, 1'b0);
        chk("rst_count", din, 16'h0000);
        step(16'h2000, 16'h0000, 1'b0);
        chk("rst_ctrl", din, 16'h0000);
        step(16'h0005, 16'h0000, 1'b0);
        chk("rst_ram_kept", din, 16'hBEEF);

        // Randomized traffic across all regions
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 5);
            d = 16'($urandom);
            case (r)
                0, 1: a = {4'h0, 4'($urandom), 8'($urandom)};
                2:    a = {4'h1, 12'($urandom)};
                3:    begin
                          a = {4'h2, 12'($urandom)};
                          if (a[1:0] == 2'd1) d = 16'($urandom_range(0, 6));
                      end
                4:    a = {4'h3, 12'($urandom)};
                default: a = {4'($urandom_range(4, 15)), 12'($urandom)};
            endcase
            if ($urandom_range(0, 7) == 0) sw = 10'($urandom);
            step(a, d, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
